alu_exec_unit: RTL and testbench

Execute stage of the KGP-RISC datapath, directly downstream of the ALU control decoder. It consumes the decoded 4-bit `alu_signal` together with two register operands and produces a registered result plus status flags for write-back and branch logic. Logic ops, add and complement complete in one cycle. Shifts and `diff` run iteratively, one bit per cycle. A valid/ready handshake on both sides stalls the pipeline while an iterative op is in flight.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_seq_shifter.sv | 93 +++++++++
 rtl/alu_exec_unit.sv | 134 +++++++++++++
 tb/tb_alu_exec_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and defaults for the KGP-RISC execute stage.
package alu_pkg;

  localparam int ALU_DATA_W = 32;

  // Decoded ALU operation coming from the ALU control decoder.
  typedef enum logic [3:0] {
    ALU_NOP  = 4'b0000,
    ALU_ADD  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_COMP = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_DIFF = 4'b1000
  } alu_sig_e;

  // Execute-stage control state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_SCAN  = 2'd2
  } exec_state_e;

endpackage

// File: rtl/alu_seq_shifter.sv
// Iterative engine: one-bit-per-cycle shifter and least-significant-set-bit
// scanner for diff. The owning FSM tells it when it is running; it raises
// done_o combinationally in the cycle whose edge completes the operation.
module alu_seq_shifter
  import alu_pkg::*;
#(
  parameter int DATA_W  = ALU_DATA_W,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  alu_sig_e          op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              run_i,
  output logic              done_o,
  output logic [DATA_W-1:0] res_o
);

  // Counter is one bit wider than the shift amount so the scan index can
  // reach DATA_W.
  localparam int CNT_W = SHAMT_W + 1;

  alu_sig_e          mode_q, mode_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shifted;
  logic              scan;
  logic              bit_hit;

  assign scan    = (mode_q == ALU_DIFF);
  assign bit_hit = data_q[cnt_q[SHAMT_W-1:0]];

  // One-position shift of the working register for the current mode.
  always_comb begin
    unique case (mode_q)
      ALU_SLL: shifted = {data_q[DATA_W-2:0], 1'b0};
      ALU_SRA: shifted = {data_q[DATA_W-1], data_q[DATA_W-1:1]};
      default: shifted = {1'b0, data_q[DATA_W-1:1]};
    endcase
  end

  // Completion detect and the value handed back to the output registers.
  always_comb begin
    done_o = 1'b0;
    res_o  = shifted;
    if (scan) begin
      res_o = bit_hit ? DATA_W'(cnt_q) : DATA_W'(DATA_W);
      if (run_i) done_o = bit_hit || (cnt_q == CNT_W'(DATA_W - 1));
    end else if (run_i) begin
      done_o = (cnt_q == CNT_W'(1));
    end
  end

  // Load on start, then shift/count down or advance the scan index.
  always_comb begin
    mode_d = mode_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (start_i) begin
      mode_d = op_i;
      if (op_i == ALU_DIFF) begin
        data_d = a_i ^ b_i;
        cnt_d  = '0;
      end else begin
        data_d = a_i;
        cnt_d  = {1'b0, b_i[SHAMT_W-1:0]};
      end
    end else if (run_i) begin
      if (scan) begin
        if (cnt_q != CNT_W'(DATA_W)) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        data_d = shifted;
        cnt_d  = cnt_q - CNT_W'(1);
      end
    end
  end

  // Engine registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= ALU_NOP;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      mode_q <= mode_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// KGP-RISC execute stage: valid/ready handshake, single-cycle datapath and
// registered result/flags; shifts and diff are delegated to alu_seq_shifter.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_W  = ALU_DATA_W,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_signal,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero,
  output logic              sign
);

  exec_state_e       state_q, state_d;
  logic [DATA_W-1:0] result_q, res_d;
  logic              carry_q, carry_d;
  logic              zero_q, sign_q, out_valid_q;
  logic              load;
  logic              accept;
  logic              eng_start;
  logic              eng_done;
  logic [DATA_W-1:0] eng_res;
  alu_sig_e          op;

  assign op       = alu_sig_e'(alu_signal);
  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  alu_seq_shifter #(
    .DATA_W (DATA_W),
    .SHAMT_W(SHAMT_W)
  ) u_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(eng_start),
    .op_i   (op),
    .a_i    (op_a),
    .b_i    (op_b),
    .run_i  (state_q != ST_IDLE),
    .done_o (eng_done),
    .res_o  (eng_res)
  );

  // Next state, single-cycle datapath and output-load decision.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    load      = 1'b0;
    eng_start = 1'b0;
    res_d     = '0;
    carry_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          load = 1'b1;
          unique case (op)
            ALU_ADD:  {carry_d, res_d} = {1'b0, op_a} + {1'b0, op_b};
            ALU_AND:  res_d = op_a & op_b;
            ALU_COMP: res_d = ~op_b + DATA_W'(1);
            ALU_XOR:  res_d = op_a ^ op_b;
            ALU_SLL, ALU_SRL, ALU_SRA: begin
              if (op_b[SHAMT_W-1:0] == '0) begin
                res_d = op_a;
              end else begin
                load      = 1'b0;
                eng_start = 1'b1;
                state_d   = ST_SHIFT;
              end
            end
            ALU_DIFF: begin
              load      = 1'b0;
              eng_start = 1'b1;
              state_d   = ST_SCAN;
            end
            default: res_d = '0;
          endcase
        end
      end
      ST_SHIFT, ST_SCAN: begin
        if (eng_done) begin
          load    = 1'b1;
          res_d   = eng_res;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Output registers: load on completion, hold until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (load) begin
      result_q    <= res_d;
      carry_q     <= carry_d;
      zero_q      <= (res_d == '0);
      sign_q      <= res_d[DATA_W-1];
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign sign      = sign_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vectors, a behavioural
// model with a scoreboard queue, and literal expectations.
module tb_alu_exec_unit;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    alu_signal;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
  logic          carry;
  logic          zero;
  logic          sign;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  alu_exec_unit #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_signal(alu_signal),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .sign      (sign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] res;
    logic          c;
    int            lat;
    int            acc;
  } exp_t;

  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected result, carry and accept-to-valid latency from the op's rules.
  function automatic exp_t model(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t          e;
    logic [DW:0]   s;
    logic [DW-1:0] x;
    int            k;
    e.c   = 1'b0;
    e.lat = 1;
    e.acc = 0;
    e.res = '0;
    k     = int'(b[4:0]);
    case (op)
      4'd1: begin s = {1'b0, a} + {1'b0, b}; e.res = s[DW-1:0]; e.c = s[DW]; end
      4'd2: e.res = a & b;
      4'd3: e.res = 32'd0 - b;
      4'd4: e.res = a ^ b;
      4'd5: begin e.res = a << k; e.lat = 1 + k; end
      4'd6: begin e.res = a >> k; e.lat = 1 + k; end
      4'd7: begin e.res = $unsigned($signed(a) >>> k); e.lat = 1 + k; end
      4'd8: begin
        x     = a ^ b;
        e.res = 32'd32;
        e.lat = 33;
        for (int i = DW - 1; i >= 0; i--) begin
          if (x[i]) begin
            e.res = 32'(i);
            e.lat = 2 + i;
          end
        end
      end
      default: e.res = '0;
    endcase
    return e;
  endfunction

  // Scoreboard compare, every cycle, sampled on the falling edge.
  exp_t mon_e;
  bit   exp_ov;
  bit   exp_ir;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_flags", {carry, zero, sign}, 0);
      q.delete();
    end else begin
      exp_ov = (q.size() > 0) && (cyc >= q[0].acc + q[0].lat);
      exp_ir = ((q.size() == 0) || exp_ov) && (!exp_ov || out_ready);
      check("mon_out_valid", out_valid, exp_ov);
      check("mon_in_ready", in_ready, exp_ir);
      if (exp_ov && out_valid) begin
        check("mon_result", result, q[0].res);
        check("mon_carry", carry, q[0].c);
        check("mon_zero", zero, q[0].res == '0);
        check("mon_sign", sign, q[0].res[DW-1]);
      end
      if (exp_ov && out_ready) void'(q.pop_front());
      if (in_valid && in_ready) begin
        mon_e     = model(alu_signal, op_a, op_b);
        mon_e.acc = cyc;
        q.push_back(mon_e);
      end
    end
  end

  // Present an op and hold it until accepted; returns #1 after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int tries = 0;
    alu_signal = op;
    op_a       = a;
    op_b       = b;
    in_valid   = 1'b1;
    do begin
      @(negedge clk);
      tries++;
    end while (!in_ready && tries < 200);
    check("accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Measure latency from the accept edge and check the literal result.
  task automatic wait_result(input string name, input logic [DW-1:0] exp_res, input int exp_lat);
    int n = 1;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      check({name, "_busy_in_ready"}, in_ready, 0);
      n++;
      @(negedge clk);
    end
    check({name, "_latency"}, n, exp_lat);
    check({name, "_result"}, result, exp_res);
    @(posedge clk);
    #1;
  endtask

  exp_t pin;

  initial begin
    rst_n      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    alu_signal = 4'd0;
    op_a       = '0;
    op_b       = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_flags", {carry, zero, sign}, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);

    // Hand-computed values pin the model.
    pin = model(4'd1, 32'hFFFF_FFFF, 32'h1);
    check("model_add", {pin.c, pin.res[30:0]}, 32'h8000_0000);
    pin = model(4'd8, 32'h8, 32'h0);
    check("model_diff", pin.res, 3);
    check("model_diff_lat", pin.lat, 5);
    pin = model(4'd7, 32'h8000_0000, 32'd31);
    check("model_sra", pin.res, 32'hFFFF_FFFF);
    pin = model(4'd8, 32'h1234_5678, 32'h1234_5678);
    check("model_diff_eq_lat", pin.lat, 33);

    // add with carry, then and accepted on the very next edge.
    issue(4'd1, 32'hFFFF_FFFF, 32'h0000_0001);
    alu_signal = 4'd2;
    op_a       = 32'hF0F0_F0F0;
    op_b       = 32'h0FF0_0FF0;
    in_valid   = 1'b1;
    @(negedge clk);
    check("add_valid", out_valid, 1);
    check("add_result", result, 0);
    check("add_carry_zero", {carry, zero}, 2'b11);
    check("b2b_in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result("and", 32'h00F0_00F0, 1);

    issue(4'd5, 32'h0000_0001, 32'd4);
    wait_result("sll4", 32'h0000_0010, 5);
    issue(4'd6, 32'h8000_0000, 32'd0);
    wait_result("srl0", 32'h8000_0000, 1);
    issue(4'd7, 32'h8000_0000, 32'd31);
    wait_result("sra31", 32'hFFFF_FFFF, 32);
    check("sra31_sign", sign, 1);
    issue(4'd3, 32'h0, 32'h0000_0001);
    wait_result("comp", 32'hFFFF_FFFF, 1);
    issue(4'd8, 32'h0000_0008, 32'h0);
    wait_result("diff3", 32'd3, 5);
    issue(4'd8, 32'h1234_5678, 32'h1234_5678);
    wait_result("diff_eq", 32'd32, 33);

    // Back-pressure: xor result held for 10 cycles.
    out_ready = 1'b0;
    issue(4'd4, 32'hA5A5_0000, 32'h5A5A_0000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_result", result, 32'hFFFF_0000);
      check("hold_flags", {carry, zero, sign}, 3'b001);
      check("hold_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready  = 1'b1;
    alu_signal = 4'd2;
    op_a       = 32'hFF00_FF00;
    op_b       = 32'h0F0F_0F0F;
    in_valid   = 1'b1;
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result("and_after_hold", 32'h0F00_0F00, 1);

    // Reset during an sll by 20 discards it.
    issue(4'd5, 32'h0000_0001, 32'd20);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_flags", {carry, zero, sign}, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("no_result_after_rst", out_valid, 0);
    end
    @(posedge clk);
    #1;
    issue(4'd1, 32'd2, 32'd3);
    wait_result("add_2_3", 32'd5, 1);

    // Undefined code behaves as NOP.
    issue(4'hF, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_result("nop", 32'd0, 1);
    check("nop_zero", zero, 1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
